// File: rtl/mips_mc_controller_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// The controller takes the master side: it samples opcode/mem_ready and
// drives every datapath enable and mux select.
interface mips_mc_controller_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_c;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       instr_done;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_c, pc_src, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, aluop, instr_done
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_c, pc_src, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, aluop, instr_done
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Main control FSM of the multi-cycle MIPS datapath. Steps each instruction
// through fetch/decode/execute/memory/writeback, stalls memory phases on
// mem_ready, and produces the 2-bit aluop for the ALU control decoder.
module mips_mc_controller #(
    parameter logic [5:0] OP_RT   = 6'b000000,
    parameter logic [5:0] OP_LW   = 6'b100011,
    parameter logic [5:0] OP_SW   = 6'b101011,
    parameter logic [5:0] OP_BEQ  = 6'b000100,
    parameter logic [5:0] OP_ADDI = 6'b001000,
    parameter logic [5:0] OP_SLTI = 6'b001010,
    parameter logic [5:0] OP_J    = 6'b000010
) (
    input  logic                        clk,
    input  logic                        rst,
    mips_mc_controller_if.master        ctrl_if
);

    typedef enum logic [3:0] {
        S_IF = 4'd0,
        S_ID = 4'd1,
        S_MA = 4'd2,
        S_ML = 4'd3,
        S_WL = 4'd4,
        S_MS = 4'd5,
        S_RX = 4'd6,
        S_WR = 4'd7,
        S_BR = 4'd8,
        S_IX = 4'd9,
        S_WI = 4'd10,
        S_JP = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_c;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       instr_done;
    } ctl_t;

    state_t state_q, state_d;
    ctl_t   ctl;

    // State register; reset returns to fetch from any state.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    // Next-state and control outputs; reset masks every output to 0.
    always_comb begin
        state_d = state_q;
        ctl     = '0;
        case (state_q)
            S_IF: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.ir_write  = ctrl_if.mem_ready;
                ctl.pc_write  = ctrl_if.mem_ready;
                if (ctrl_if.mem_ready) state_d = S_ID;
            end
            S_ID: begin
                ctl.alu_src_b = 2'b11;
                if (ctrl_if.opcode == OP_LW || ctrl_if.opcode == OP_SW)
                    state_d = S_MA;
                else if (ctrl_if.opcode == OP_RT)
                    state_d = S_RX;
                else if (ctrl_if.opcode == OP_BEQ)
                    state_d = S_BR;
                else if (ctrl_if.opcode == OP_ADDI || ctrl_if.opcode == OP_SLTI)
                    state_d = S_IX;
                else if (ctrl_if.opcode == OP_J)
                    state_d = S_JP;
                else begin
                    ctl.instr_done = 1'b1;
                    state_d        = S_IF;
                end
            end
            S_MA: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                if (ctrl_if.opcode == OP_LW)      state_d = S_ML;
                else if (ctrl_if.opcode == OP_SW) state_d = S_MS;
                else                              state_d = S_IF;
            end
            S_ML: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (ctrl_if.mem_ready) state_d = S_WL;
            end
            S_WL: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = S_IF;
            end
            S_MS: begin
                ctl.mem_write  = 1'b1;
                ctl.i_or_d     = 1'b1;
                ctl.instr_done = ctrl_if.mem_ready;
                if (ctrl_if.mem_ready) state_d = S_IF;
            end
            S_RX: begin
                ctl.alu_src_a = 1'b1;
                ctl.aluop     = 2'b10;
                state_d       = S_WR;
            end
            S_WR: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = S_IF;
            end
            S_BR: begin
                ctl.alu_src_a  = 1'b1;
                ctl.aluop      = 2'b01;
                ctl.pc_write_c = 1'b1;
                ctl.pc_src     = 2'b01;
                ctl.instr_done = 1'b1;
                state_d        = S_IF;
            end
            S_IX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.aluop     = (ctrl_if.opcode == OP_SLTI) ? 2'b11 : 2'b00;
                state_d       = S_WI;
            end
            S_WI: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = S_IF;
            end
            S_JP: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_src     = 2'b10;
                ctl.instr_done = 1'b1;
                state_d        = S_IF;
            end
            default: state_d = S_IF;
        endcase
        if (rst) ctl = '0;
    end

    assign ctrl_if.pc_write   = ctl.pc_write;
    assign ctrl_if.pc_write_c = ctl.pc_write_c;
    assign ctrl_if.pc_src     = ctl.pc_src;
    assign ctrl_if.i_or_d     = ctl.i_or_d;
    assign ctrl_if.mem_read   = ctl.mem_read;
    assign ctrl_if.mem_write  = ctl.mem_write;
    assign ctrl_if.ir_write   = ctl.ir_write;
    assign ctrl_if.reg_dst    = ctl.reg_dst;
    assign ctrl_if.mem_to_reg = ctl.mem_to_reg;
    assign ctrl_if.reg_write  = ctl.reg_write;
    assign ctrl_if.alu_src_a  = ctl.alu_src_a;
    assign ctrl_if.alu_src_b  = ctl.alu_src_b;
    assign ctrl_if.aluop      = ctl.aluop;
    assign ctrl_if.instr_done = ctl.instr_done;

endmodule
